// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl
// LED pattern sequencer. A one-hot command selects the running mode (hold the
// default pattern, rotate left, rotate right, pause, or bounce between the
// ends). A step counter divides clk down to the step rate, and spd picks one of
// four rates. A load strobe replaces the pattern in any mode except RESET.
module led_seq_ctrl #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(8'h03),
    parameter int unsigned      DIV     = 125000000,
    parameter int unsigned      CNT_W   = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       cmd,
    input  logic [1:0]       spd,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pat,
    output logic [WIDTH-1:0] led,
    output logic [2:0]       state_o,
    output logic             step
);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_SHIFT_L = 3'd1,
        ST_SHIFT_R = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_BOUNCE  = 3'd4
    } state_e;

    // One extra bit lets DIV == 2^CNT_W be represented before the shift.
    localparam int unsigned   PW    = CNT_W + 1;
    localparam logic [PW-1:0] DIV_V = PW'(DIV);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;

    logic [CNT_W-1:0] periodM1;
    logic             tick;
    logic             stateChange;
    logic             bounceEntry;
    logic             loadTaken;
    logic [WIDTH-1:0] rotL;
    logic [WIDTH-1:0] rotR;

    // Decode the command: exactly one bit set selects a state, anything else holds.
    always_comb begin
        state_d = state_q;
        case (cmd)
            5'b00001: state_d = ST_RESET;
            5'b00010: state_d = ST_SHIFT_L;
            5'b00100: state_d = ST_SHIFT_R;
            5'b01000: state_d = ST_PAUSE;
            5'b10000: state_d = ST_BOUNCE;
            default:  state_d = state_q;
        endcase
    end

    // Current step period and tick. The compare is >= so a speed-up mid-count fires at once.
    always_comb begin
        periodM1 = CNT_W'((DIV_V >> spd) - PW'(1));
        tick     = (cnt_q >= periodM1);
    end

    // Qualifiers shared by the counter and pattern logic, plus both rotations of the pattern.
    always_comb begin
        stateChange = (state_d != state_q);
        bounceEntry = (state_d == ST_BOUNCE) && (state_q != ST_BOUNCE);
        loadTaken   = load && (state_q != ST_RESET);
        rotL        = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        rotR        = {led_q[0], led_q[WIDTH-1:1]};
    end

    // Step counter: restarts on a state change so a new mode gets a full period first.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (stateChange || tick) begin
            cnt_d = '0;
        end
    end

    // Pattern, bounce direction and step pulse, driven by the state the edge leaves.
    always_comb begin
        led_d  = led_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        case (state_q)
            ST_RESET: begin
                led_d = DEF_PAT;
            end
            ST_SHIFT_L: begin
                if (tick) begin
                    led_d  = rotL;
                    step_d = 1'b1;
                end
            end
            ST_SHIFT_R: begin
                if (tick) begin
                    led_d  = rotR;
                    step_d = 1'b1;
                end
            end
            ST_BOUNCE: begin
                if (tick) begin
                    step_d = 1'b1;
                    if (!dir_q && led_q[WIDTH-1]) begin
                        dir_d = 1'b1;
                        led_d = rotR;
                    end else if (dir_q && led_q[0]) begin
                        dir_d = 1'b0;
                        led_d = rotL;
                    end else begin
                        led_d = dir_q ? rotR : rotL;
                    end
                end
            end
            default: begin
                led_d = led_q;
            end
        endcase

        // A load overrides a coincident step completely: no rotation, no direction change, no pulse.
        if (loadTaken) begin
            led_d  = load_pat;
            dir_d  = dir_q;
            step_d = 1'b0;
        end

        // Bounce always starts by moving left.
        if (bounceEntry) begin
            dir_d = 1'b0;
        end
    end

    // State and datapath registers; rst forces the idle RESET condition immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            led_q   <= DEF_PAT;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    assign led     = led_q;
    assign state_o = state_q;
    assign step    = step_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl
// Self-checking bench for led_seq_ctrl (WIDTH=8, DEF_PAT=03, DIV=8). A small
// behavioural model tracks mode, pattern, bounce direction and the step period
// with plain integer arithmetic; directed scenarios are followed by random traffic.
`timescale 1ns/1ps
module tb_led_seq_ctrl;

    localparam int         DIV = 8;
    localparam logic [7:0] DEF = 8'h03;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] cmd = '0;
    logic [1:0] spd = '0;
    logic       load = 1'b0;
    logic [7:0] load_pat = '0;
    logic [7:0] led;
    logic [2:0] state_o;
    logic       step;

    int errors = 0;
    int checks = 0;

    // Model of the sequencer's visible behaviour.
    int         mState;
    logic [7:0] mLed;
    bit         mDir;
    int         mCnt;
    bit         mStep;

    logic [7:0] r34Seq [3] = '{8'h81, 8'hC0, 8'h60};
    logic [7:0] r35Seq [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    led_seq_ctrl #(
        .WIDTH   (8),
        .DEF_PAT (8'h03),
        .DIV     (8),
        .CNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .spd      (spd),
        .load     (load),
        .load_pat (load_pat),
        .led      (led),
        .state_o  (state_o),
        .step     (step)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [7:0] rotLeft(input logic [7:0] x);
        int v;
        v = int'(x);
        return 8'((v * 2) % 256 + v / 128);
    endfunction

    function automatic logic [7:0] rotRight(input logic [7:0] x);
        int v;
        v = int'(x);
        return 8'(v / 2 + (v % 2) * 128);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0;
        mLed   = DEF;
        mDir   = 1'b0;
        mCnt   = 0;
        mStep  = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic modelNext(input logic [4:0] c, input logic [1:0] s, input logic l, input logic [7:0] p);
        int         period;
        int         nState;
        int         ones;
        int         idx;
        bit         tick;
        logic [7:0] nLed;
        bit         nDir;
        bit         nStep;
        period = DIV >> s;
        tick   = (mCnt >= period - 1);
        ones   = 0;
        idx    = 0;
        for (int i = 0; i < 5; i++) begin
            if (c[i]) begin
                ones++;
                idx = i;
            end
        end
        nState = (ones == 1) ? idx : mState;
        nLed   = mLed;
        nDir   = mDir;
        nStep  = 1'b0;
        if (mState == 0) begin
            nLed = DEF;
        end else if (l) begin
            nLed = p;
        end else if (tick && mState != 3) begin
            nStep = 1'b1;
            if (mState == 1) begin
                nLed = rotLeft(mLed);
            end else if (mState == 2) begin
                nLed = rotRight(mLed);
            end else if (!mDir && mLed[7]) begin
                nDir = 1'b1;
                nLed = rotRight(mLed);
            end else if (mDir && mLed[0]) begin
                nDir = 1'b0;
                nLed = rotLeft(mLed);
            end else begin
                nLed = mDir ? rotRight(mLed) : rotLeft(mLed);
            end
        end
        if (nState == 4 && mState != 4) begin
            nDir = 1'b0;
        end
        mCnt   = (nState != mState || tick) ? 0 : mCnt + 1;
        mState = nState;
        mLed   = nLed;
        mDir   = nDir;
        mStep  = nStep;
    endtask

    // Check the outputs against the model at the falling edge, then drive the next inputs.
    task automatic applyStimulus(input logic [4:0] c, input logic [1:0] s, input logic l, input logic [7:0] p);
        @(negedge clk);
        checkOutput("led", 32'(led), 32'(mLed));
        checkOutput("state", 32'(state_o), 32'(mState));
        checkOutput("step", 32'(step), 32'(mStep));
        cmd      = c;
        spd      = s;
        load     = l;
        load_pat = p;
        modelNext(c, s, l, p);
    endtask

    // Check fixed expected values just after the coming rising edge.
    task automatic checkNextEdge(input string tag, input logic [7:0] expLed, input logic expStep,
                                 input logic [2:0] expState);
        @(posedge clk);
        #1;
        checkOutput({tag, "_led"}, 32'(led), 32'(expLed));
        checkOutput({tag, "_step"}, 32'(step), 32'(expStep));
        checkOutput({tag, "_state"}, 32'(state_o), 32'(expState));
    endtask

    // Pulse rst between edges and check that it takes effect without a clock.
    task automatic pulseReset();
        @(negedge clk);
        checkOutput("led", 32'(led), 32'(mLed));
        checkOutput("state", 32'(state_o), 32'(mState));
        checkOutput("step", 32'(step), 32'(mStep));
        cmd  = '0;
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_led", 32'(led), 32'(DEF));
        checkOutput("arst_state", 32'(state_o), 32'd0);
        checkOutput("arst_step", 32'(step), 32'd0);
        modelReset();
        #1 rst = 1'b0;
        modelNext(cmd, spd, load, load_pat);
    endtask

    initial begin
        logic [4:0] rc;
        logic [1:0] rs;
        logic       rl;
        int         r;

        modelReset();
        #12;
        checkOutput("por_led", 32'(led), 32'(DEF));
        checkOutput("por_state", 32'(state_o), 32'd0);
        checkOutput("por_step", 32'(step), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        modelNext(cmd, spd, load, load_pat);

        // Left rotation at the slowest rate: a step every 8 cycles.
        applyStimulus(5'b00010, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r33_go", 8'h03, 1'b0, 3'd1);
        repeat (8) applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r33_s1", 8'h06, 1'b1, 3'd1);
        repeat (8) applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r33_s2", 8'h0C, 1'b1, 3'd1);

        // Right rotation from the default pattern with a 2-cycle period.
        applyStimulus(5'b00001, 2'd2, 1'b0, 8'h00);
        applyStimulus(5'b00000, 2'd2, 1'b0, 8'h00);
        applyStimulus(5'b00100, 2'd2, 1'b0, 8'h00);
        checkNextEdge("r34_go", 8'h03, 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            repeat (2) applyStimulus(5'b00000, 2'd2, 1'b0, 8'h00);
            checkNextEdge($sformatf("r34_%0d", i), r34Seq[i], 1'b1, 3'd2);
        end

        // Bounce from a loaded 40: reaches the top, turns, runs down to bit 0, turns again.
        applyStimulus(5'b10000, 2'd2, 1'b1, 8'h40);
        checkNextEdge("r35_go", 8'h40, 1'b0, 3'd4);
        for (int i = 0; i < 9; i++) begin
            repeat (2) applyStimulus(5'b00000, 2'd2, 1'b0, 8'h00);
            checkNextEdge($sformatf("r35_%0d", i), r35Seq[i], 1'b1, 3'd4);
        end

        // Pause holds the pattern, and the next mode resumes from it.
        applyStimulus(5'b00010, 2'd2, 1'b1, 8'h0C);
        checkNextEdge("r36_ld", 8'h0C, 1'b0, 3'd1);
        applyStimulus(5'b01000, 2'd2, 1'b0, 8'h00);
        checkNextEdge("r36_pause", 8'h0C, 1'b0, 3'd3);
        repeat (40) applyStimulus(5'b00000, 2'd2, 1'b0, 8'h00);
        checkNextEdge("r36_hold", 8'h0C, 1'b0, 3'd3);
        applyStimulus(5'b00100, 2'd2, 1'b0, 8'h00);
        checkNextEdge("r36_go", 8'h0C, 1'b0, 3'd2);
        repeat (2) applyStimulus(5'b00000, 2'd2, 1'b0, 8'h00);
        checkNextEdge("r36_res", 8'h06, 1'b1, 3'd2);

        // Invalid commands are ignored; a load on the tick cycle wins over the step.
        applyStimulus(5'b00010, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r37_go", 8'h06, 1'b0, 3'd1);
        applyStimulus(5'b00110, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r37_multi", 8'h06, 1'b0, 3'd1);
        applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r37_zero", 8'h06, 1'b0, 3'd1);
        repeat (5) applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        applyStimulus(5'b00000, 2'd0, 1'b1, 8'hAA);
        checkNextEdge("r37_ld", 8'hAA, 1'b0, 3'd1);
        repeat (8) applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        checkNextEdge("r37_wrap", 8'h55, 1'b1, 3'd1);

        // Asynchronous reset in the middle of a count.
        repeat (3) applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        pulseReset();
        applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);

        // Load is ignored while in RESET.
        applyStimulus(5'b00000, 2'd0, 1'b1, 8'h5A);
        checkNextEdge("r28_ign", 8'h03, 1'b0, 3'd0);

        // Bounce with all-ones and all-zero patterns at one step per cycle.
        applyStimulus(5'b10000, 2'd3, 1'b0, 8'h00);
        applyStimulus(5'b00000, 2'd3, 1'b1, 8'hFF);
        repeat (6) applyStimulus(5'b00000, 2'd3, 1'b0, 8'h00);
        checkNextEdge("ones", 8'hFF, 1'b1, 3'd4);
        applyStimulus(5'b00000, 2'd3, 1'b1, 8'h00);
        repeat (6) applyStimulus(5'b00000, 2'd3, 1'b0, 8'h00);
        checkNextEdge("zeros", 8'h00, 1'b1, 3'd4);

        // Speeding up past the current count fires a step on the next edge.
        applyStimulus(5'b00010, 2'd0, 1'b1, 8'h11);
        repeat (6) applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);
        applyStimulus(5'b00000, 2'd2, 1'b0, 8'h00);
        checkNextEdge("spd_jump", 8'h22, 1'b1, 3'd1);

        // Random traffic: mostly idle cycles so steps happen, plus commands, loads, speed changes and resets.
        rs = 2'd0;
        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                pulseReset();
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 80) begin
                    rc = 5'b00000;
                end else if (r < 93) begin
                    rc = 5'(1 << $urandom_range(0, 4));
                end else begin
                    rc = 5'($urandom_range(0, 31));
                end
                if ($urandom_range(0, 99) < 8) begin
                    rs = 2'($urandom_range(0, 3));
                end
                rl = ($urandom_range(0, 99) < 5);
                applyStimulus(rc, rs, rl, 8'($urandom_range(0, 255)));
            end
        end
        applyStimulus(5'b00000, 2'd0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, LED vector width (>=2).
REQ-002 Parameter DEF_PAT, default 8'h03 (WIDTH bits), pattern loaded in RESET state.
REQ-003 Parameter DIV, default 125000000, base step period in clk cycles (>=8).
REQ-004 Parameter CNT_W, default 27, step-counter width; SHALL satisfy 2^CNT_W >= DIV.
REQ-005 Port clk  input  1  clock, rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port cmd  input  5  one-hot command: [0] RESET, [1] SHIFT_L, [2] SHIFT_R, [3] PAUSE, [4] BOUNCE.
REQ-008 Port spd  input  2  speed select; step period = DIV >> spd.
REQ-009 Port load  input  1  single-cycle pattern-load strobe.
REQ-010 Port load_pat  input  WIDTH  pattern captured on load.
REQ-011 Port led  output  WIDTH  registered LED pattern.
REQ-012 Port state_o  output  3  current state: 0 RESET, 1 SHIFT_L, 2 SHIFT_R, 3 PAUSE, 4 BOUNCE.
REQ-013 Port step  output  1  registered one-cycle pulse, high the cycle after led changes due to a step.

Function
REQ-014 States RESET, SHIFT_L, SHIFT_R, PAUSE, BOUNCE; next state registered, one-cycle latency from cmd.
REQ-015 A valid cmd (exactly one bit set) SHALL move to the named state from any state; cmd equal to current state keeps state.
REQ-016 cmd of zero or more than one bit set SHALL be ignored (state held).
REQ-017 Step counter counts 0..T-1, T = DIV >> spd; tick asserted when counter >= T-1, counter then wraps to 0.
REQ-018 Counter SHALL clear to 0 on every state change, so first step after a command occurs T cycles after state_o updates.
REQ-019 spd change mid-count takes effect immediately; if counter already >= new T-1, tick fires next cycle.
REQ-020 RESET: led = DEF_PAT every cycle; no steps.
REQ-021 SHIFT_L on tick: led rotates left, led[0] <= led[WIDTH-1].
REQ-022 SHIFT_R on tick: led rotates right, led[WIDTH-1] <= led[0].
REQ-023 PAUSE: led held; leaving PAUSE resumes from held pattern (no reload).
REQ-024 BOUNCE: internal dir bit (0 left, 1 right); on tick, if dir=0 and led[WIDTH-1]=1, dir <= 1 and rotate right, else if dir=1 and led[0]=1, dir <= 0 and rotate left, else rotate in dir.
REQ-025 dir SHALL clear to 0 on entry to BOUNCE.
REQ-026 All-zero pattern: rotations keep zero, dir never flips; all-ones pattern: dir flips every tick, led unchanged.
REQ-027 load in any state except RESET: led <= load_pat next cycle; load has priority over a coincident tick (step not asserted, counter still wraps).
REQ-028 load in RESET ignored.
REQ-029 load coincident with valid cmd: both take effect; led <= load_pat, state changes.
REQ-030 step SHALL be 0 in RESET, PAUSE and on load cycles.

Reset
REQ-031 rst SHALL asynchronously set state RESET, led = DEF_PAT, counter = 0, dir = 0, step = 0.
REQ-032 rst asserted mid-step SHALL abort it; first edge after deassertion evaluates cmd normally.

Verification (WIDTH=8, DEF_PAT=8'h03, DIV=8)
REQ-033 rst, then cmd=00010, spd=0 -> state_o=1 next cycle; led 03->06 after 8 cycles, ->0C after 8 more, step pulses each time.
REQ-034 SHIFT_R, spd=2 (T=2) from 03 -> led 81, C0, 60 on every 2nd cycle.
REQ-035 BOUNCE from load_pat=8'h40 -> led 80, 40 (dir flip), 20 ... down to 01, then 02; state_o=4 throughout.
REQ-036 SHIFT_L with led=0C, cmd=01000 -> led holds 0C for 40 cycles; cmd=00100 -> resumes right rotation to 06.
REQ-037 cmd=00110 or 00000 in SHIFT_L -> state stays 1; load=1, load_pat=AA on tick cycle -> led=AA, step=0.
REQ-038 rst pulse mid-count in SHIFT_L -> led=03, state_o=0 immediately, step=0.
